// File: rtl/dpcm_pkg.sv
// Shared DPCM definitions used by both the encoder and decoder stages.
package dpcm_pkg;

  localparam int DPCM_W = 8;
  localparam logic signed [DPCM_W-1:0] DPCM_MAX = 8'sh7F;
  localparam logic signed [DPCM_W-1:0] DPCM_MIN = 8'sh80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } dpcm_state_e;

endpackage

// File: rtl/dpcm_clamp.sv
// Clamps the 9-bit reconstruction sum into the 8-bit signed sample range.
module dpcm_clamp
  import dpcm_pkg::*;
(
  input  logic signed [DPCM_W:0]   sum,
  output logic signed [DPCM_W-1:0] res
);

  // The two top bits disagree exactly when the sum has left the 8-bit range.
  function automatic logic signed [DPCM_W-1:0] sat(input logic signed [DPCM_W:0] x);
    if (x[DPCM_W] != x[DPCM_W-1])
      return x[DPCM_W] ? DPCM_MIN : DPCM_MAX;
    return x[DPCM_W-1:0];
  endfunction

  assign res = sat(sum);

endmodule

// File: rtl/dpcm_dec.sv
// DPCM decoder behind an APB-style slave: writes accumulate difference codes.
// Define DPCM_DEC_SAT_EN to saturate the accumulator instead of wrapping it.
module dpcm_dec
  import dpcm_pkg::*;
(
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic signed [DPCM_W-1:0] pwdata,
  output logic signed [DPCM_W-1:0] prdata,
  output logic                     pready,
  output logic signed [DPCM_W-1:0] sample,
  output logic                     sample_valid,
  output logic [1:0]               estado
);

  localparam int DATA_W = DPCM_W;

  dpcm_state_e state, state_nxt;
  logic                     xfer_done;
  logic                     wr_p0;
  logic signed [DATA_W:0]   sum_p0;
  logic signed [DATA_W-1:0] f_p0;
  logic signed [DATA_W-1:0] acc_p1;
  logic signed [DATA_W-1:0] sample_p1;
  logic                     vld_p1;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    xfer_done = 1'b0;
    case (state)
      IDLE:    state_nxt = psel ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (psel && penable) begin
          xfer_done = 1'b1;
          state_nxt = psel ? SETUP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: completed write forms the sign-extended 9-bit sum
  assign wr_p0  = xfer_done && pwrite;
  assign sum_p0 = {pwdata[DATA_W-1], pwdata} + {acc_p1[DATA_W-1], acc_p1};

`ifdef DPCM_DEC_SAT_EN
  dpcm_clamp u_clamp (
    .sum (sum_p0),
    .res (f_p0)
  );
`else
  function automatic logic signed [DATA_W-1:0] wrap(input logic signed [DATA_W-1:0] x);
    return x;
  endfunction

  logic unused_carry;
  assign unused_carry = sum_p0[DATA_W];
  assign f_p0 = wrap(sum_p0[DATA_W-1:0]);
`endif

  // Stage p1: accumulator, registered sample and its valid pulse
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      acc_p1    <= '0;
      sample_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= wr_p0;
      if (wr_p0) begin
        acc_p1    <= f_p0;
        sample_p1 <= f_p0;
      end
    end
  end

  assign prdata       = acc_p1;
  assign sample       = sample_p1;
  assign sample_valid = vld_p1;
  assign pready       = (state == ACCESS);
  assign estado       = state;

endmodule
